// File: rtl/registers64_reader.sv
// registers64_reader: streams the first N words of a 64-entry register bank
// out over a valid/ready port in index order, one word per cycle.
module registers64_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 64,
  parameter int IDX_W      = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [IDX_W:0]                 count,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] din_flat,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [DATA_WIDTH-1:0]          m_data,
  output logic [IDX_W-1:0]               m_index,
  output logic                           m_last,
  output logic                           busy,
  output logic                           done
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FINISH
  } state_e;

  localparam logic [IDX_W:0] MAX_N = (IDX_W+1)'(NUM_REGS);
  localparam logic [IDX_W:0] ONE_N = (IDX_W+1)'(1);
  localparam logic [IDX_W:0] ZERO_N = '0;

  state_e                  state_q, state_d;
  logic [IDX_W:0]          n_q, n_d;
  logic                    m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
  logic [IDX_W-1:0]        m_index_q, m_index_d;
  logic                    m_last_q, m_last_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic [DATA_WIDTH-1:0]   words [NUM_REGS];
  logic [IDX_W:0]          n_sat;
  logic [IDX_W-1:0]        idx_nx;
  logic                    last_nx;
  logic                    xfer;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_words
    assign words[k] = din_flat[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // Saturated length, next index and its last-word flag
  always_comb begin
    n_sat   = (count > MAX_N) ? MAX_N : count;
    idx_nx  = m_index_q + 1'b1;
    last_nx = ({1'b0, idx_nx} == (n_q - ONE_N));
    xfer    = m_valid_q && m_ready;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_index_d = m_index_q;
    m_last_d  = m_last_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          n_d = n_sat;
          if (n_sat == ZERO_N) begin
            state_d = FINISH;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d   = STREAM;
            m_valid_d = 1'b1;
            m_data_d  = words[0];
            m_index_d = '0;
            m_last_d  = (n_sat == ONE_N);
            busy_d    = 1'b1;
          end
        end
      end
      STREAM: begin
        if (xfer) begin
          if (m_last_q) begin
            state_d   = FINISH;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
          end else begin
            m_data_d  = words[idx_nx];
            m_index_d = idx_nx;
            m_last_d  = last_nx;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      n_q       <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_index_q <= '0;
      m_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_index_q <= m_index_d;
      m_last_q  <= m_last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_index = m_index_q;
  assign m_last  = m_last_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_registers64_reader.sv
// tb_registers64_reader: table-driven passes with a beat scoreboard,
// plus hand-written reset-mid-pass sequence.
module tb_registers64_reader;

  localparam int DW = 16;
  localparam int NR = 64;
  localparam int IW = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [IW:0]     count;
  logic [NR*DW-1:0] din_flat;
  logic            m_valid;
  logic            m_ready;
  logic [DW-1:0]   m_data;
  logic [IW-1:0]   m_index;
  logic            m_last;
  logic            busy;
  logic            done;

  logic [DW-1:0]   bank [NR];

  typedef struct {
    int cnt;
    int mode;
    int exp_n;
    int inject;
  } vec_t;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [IW-1:0] i;
    logic          l;
  } beat_t;

  vec_t  vecs [8];
  beat_t sbq [$];
  int    pat [7];
  int    checks = 0;
  int    errors = 0;

  registers64_reader #(
    .DATA_WIDTH(DW),
    .NUM_REGS(NR),
    .IDX_W(IW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .count(count),
    .din_flat(din_flat),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .m_index(m_index),
    .m_last(m_last),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  always_comb begin
    din_flat = '0;
    for (int k = 0; k < NR; k++) din_flat[k*DW +: DW] = bank[k];
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic ready_for(input int mode, input int c);
    if (mode == 1 || mode == 4) return (c <= 7) ? pat[c-1][0] : 1'b1;
    if (mode == 2) return 1'($urandom_range(0, 1));
    return 1'b1;
  endfunction

  task automatic run_pass(input vec_t v);
    int    beats;
    int    last_beat;
    int    done_c;
    logic  hv;
    beat_t held;
    beat_t e;
    beat_t got;
    if (v.mode == 4) bank[2] = 16'h0002;
    for (int i = 0; i < v.exp_n; i++) begin
      e.d = (v.mode == 4 && i == 2) ? 16'hBEEF : bank[i];
      e.i = IW'(i);
      e.l = (i == v.exp_n - 1);
      sbq.push_back(e);
    end
    count   = (IW+1)'(v.cnt);
    start   = 1'b1;
    m_ready = 1'b0;
    @(negedge clk);
    start     = 1'b0;
    beats     = 0;
    last_beat = -1;
    done_c    = -1;
    hv        = 1'b0;
    held      = '0;
    for (int c = 1; c <= 400 && done_c < 0; c++) begin
      if (c == 1) chk("first_valid", 32'(m_valid), 32'(v.exp_n > 0));
      if (hv) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_word", 32'({m_data, m_index, m_last}), 32'(held));
      end
      m_ready = ready_for(v.mode, c);
      if (m_valid) begin
        chk("busy_valid", 32'(busy), 32'd1);
        if (m_ready) begin
          got = {m_data, m_index, m_last};
          if (sbq.size() == 0) begin
            chk("sb_extra_beat", 32'(got), 32'd0);
            chk("sb_underflow", 32'd1, 32'd0);
          end else begin
            e = sbq.pop_front();
            chk("beat_data", 32'(m_data), 32'(e.d));
            chk("beat_index", 32'(m_index), 32'(e.i));
            chk("beat_last", 32'(m_last), 32'(e.l));
          end
          beats++;
          last_beat = c;
        end
      end
      if (done) begin
        done_c = c;
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_valid", 32'(m_valid), 32'd0);
        chk("beat_count", 32'(beats), 32'(v.exp_n));
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        if (v.exp_n > 0) chk("done_lat", 32'(done_c), 32'(last_beat + 1));
        else chk("done_lat0", 32'(done_c), 32'd1);
        if (v.mode == 0 && v.inject == 0)
          chk("done_abs", 32'(done_c), 32'(v.exp_n + 1));
      end
      hv   = m_valid && !m_ready;
      held = {m_data, m_index, m_last};
      start = (v.inject > 0 && c == v.inject);
      if (start) count = 7'd2;
      if (v.mode == 4 && c == 2) bank[2] = 16'hBEEF;
      @(negedge clk);
    end
    start = 1'b0;
    if (done_c < 0) chk("done_timeout", 32'd0, 32'd1);
    for (int j = 0; j < 3; j++) begin
      chk("idle_after", 32'({m_valid, done, busy}), 32'd0);
      @(negedge clk);
    end
    sbq.delete();
    if (v.mode == 4) bank[2] = 16'h1002;
  endtask

  initial begin
    vecs[0] = '{64, 0, 64, 0};
    vecs[1] = '{4, 1, 4, 0};
    vecs[2] = '{0, 0, 0, 0};
    vecs[3] = '{1, 0, 1, 0};
    vecs[4] = '{100, 0, 64, 0};
    vecs[5] = '{8, 0, 8, 3};
    vecs[6] = '{7, 2, 7, 0};
    vecs[7] = '{4, 4, 4, 0};
    pat = '{1, 0, 0, 1, 1, 0, 1};
    for (int k = 0; k < NR; k++) bank[k] = DW'(16'h1000 + k);

    rst     = 1'b1;
    start   = 1'b0;
    count   = '0;
    m_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_outputs",
        32'({m_valid, m_data, m_index, m_last, busy, done}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 8; v++) run_pass(vecs[v]);

    count   = 7'd10;
    start   = 1'b1;
    m_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (m_valid && m_index == 6'd5) begin
        m_ready = 1'b0;
        break;
      end
      m_ready = 1'b1;
      @(negedge clk);
    end
    chk("mid_idx5", 32'({m_valid, m_index}), 32'({1'b1, 6'd5}));
    @(negedge clk);
    chk("mid_stall", 32'({m_valid, m_data, m_index}),
        32'({1'b1, 16'h1005, 6'd5}));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_out",
        32'({m_valid, busy, done, m_index, m_data, m_last}), 32'd0);
    m_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_nodone", 32'({m_valid, busy, done}), 32'd0);
    run_pass('{3, 0, 3, 0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
